// File: rtl/gpmc_sram_ctrl.sv
// GPMC synchronous slave sequencer: latches the multiplexed address phase, then turns
// each data beat into a one-cycle SRAM strobe, auto-incrementing the word address.
module gpmc_sram_ctrl #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  GPMC_CLK,
  input  logic                  RST_N,
  input  logic [15:0]           GPMC_AD_IN,
  output logic [15:0]           GPMC_DATA_OUT,
  output logic                  GPMC_DATA_OE,
  input  logic                  GPMC_CS,
  input  logic                  GPMC_ADV,
  input  logic                  GPMC_OE,
  input  logic                  GPMC_WE,
  input  logic                  GPMC_BE0,
  input  logic                  GPMC_BE1,
  input  logic                  GPMC_WP,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [15:0]           MEM_WDATA,
  output logic [1:0]            MEM_BE,
  output logic                  MEM_WE,
  output logic                  MEM_RE,
  input  logic [15:0]           MEM_RDATA,
  output logic                  WP_VIOL
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  rd_valid;
  logic                  addr_phase;
  logic                  data_phase;
  logic                  wr_beat;
  logic                  rd_beat;

  // A write strobe wins over a read strobe when both are low.
  assign addr_phase = !GPMC_CS && !GPMC_ADV;
  assign data_phase = (state == ACTIVE) && !GPMC_CS && GPMC_ADV;
  assign wr_beat    = data_phase && !GPMC_WE;
  assign rd_beat    = data_phase && GPMC_WE && !GPMC_OE;

  always_ff @(posedge GPMC_CLK) begin
    if (!RST_N) begin
      state         <= IDLE;
      addr          <= '0;
      rd_valid      <= 1'b0;
      GPMC_DATA_OUT <= '0;
      GPMC_DATA_OE  <= 1'b0;
      MEM_ADDR      <= '0;
      MEM_WDATA     <= '0;
      MEM_BE        <= '0;
      MEM_WE        <= 1'b0;
      MEM_RE        <= 1'b0;
      WP_VIOL       <= 1'b0;
    end else begin
      MEM_WE  <= 1'b0;
      MEM_RE  <= 1'b0;
      WP_VIOL <= 1'b0;

      // Read pipeline: MEM_RE -> SRAM access -> bus capture; chip-select high flushes it.
      rd_valid     <= MEM_RE && !GPMC_CS;
      GPMC_DATA_OE <= rd_valid && !GPMC_CS;
      if (rd_valid && !GPMC_CS) begin
        GPMC_DATA_OUT <= MEM_RDATA;
      end

      case (state)
        IDLE: begin
          if (addr_phase) begin
            addr  <= GPMC_AD_IN[ADDR_WIDTH-1:0];
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (GPMC_CS) begin
            state <= IDLE;
          end else if (!GPMC_ADV) begin
            addr <= GPMC_AD_IN[ADDR_WIDTH-1:0];
          end else if (wr_beat) begin
            MEM_ADDR  <= addr;
            MEM_WDATA <= GPMC_AD_IN;
            MEM_BE    <= {!GPMC_BE1, !GPMC_BE0};
            MEM_WE    <= GPMC_WP;
            WP_VIOL   <= !GPMC_WP;
            addr      <= addr + 1'b1;
          end else if (rd_beat) begin
            MEM_ADDR <= addr;
            MEM_RE   <= 1'b1;
            addr     <= addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gpmc_sram_ctrl.md
Name: gpmc_sram_ctrl

Overview:
Synchronous GPMC slave bus-cycle sequencer that sits between the multiplexed GPMC address/data pins and an on-FPGA synchronous SRAM. It latches the address phase, turns each data-phase beat into a single-cycle SRAM write or read strobe, auto-increments the address for bursts, and drives returned read data back onto the GPMC data bus with an output enable. It is the control block that the gpmc_sram pin-level wrapper instantiates.

Parameters:
ADDR_WIDTH, 10, SRAM word-address width; must be between 1 and 16; address taken from GPMC_AD_IN[ADDR_WIDTH-1:0].

Ports:
GPMC_CLK  in  1  GPMC bus clock; all logic on rising edge
RST_N  in  1  synchronous reset, active-low
GPMC_AD_IN  in  16  multiplexed address/data from GPMC
GPMC_DATA_OUT  out  16  read data toward GPMC
GPMC_DATA_OE  out  1  1 = pad drives GPMC_DATA_OUT
GPMC_CS  in  1  chip select, active-low
GPMC_ADV  in  1  address valid, active-low
GPMC_OE  in  1  read strobe, active-low
GPMC_WE  in  1  write strobe, active-low
GPMC_BE0  in  1  byte enable low byte, active-low
GPMC_BE1  in  1  byte enable high byte, active-low
GPMC_WP  in  1  write protect, active-low (0 = writes blocked)
MEM_ADDR  out  ADDR_WIDTH  SRAM word address
MEM_WDATA  out  16  SRAM write data
MEM_BE  out  2  SRAM byte enables, active-high, {hi,lo}
MEM_WE  out  1  SRAM write strobe, 1-cycle pulse per beat
MEM_RE  out  1  SRAM read strobe, 1-cycle pulse per beat
MEM_RDATA  in  16  SRAM read data, valid the cycle after MEM_RE
WP_VIOL  out  1  1-cycle pulse when a write beat is blocked by WP

Behaviour:
- Reset (RST_N=0 at an edge): state IDLE, addr register 0, every output 0 (GPMC_DATA_OUT=0, GPMC_DATA_OE=0, MEM_*=0, WP_VIOL=0), read pipeline valid bits cleared. Reset overrides all inputs, including mid-burst.
- States: IDLE, ACTIVE.
- IDLE: if CS=0 and ADV=0, addr <= AD_IN[ADDR_WIDTH-1:0], go to ACTIVE. Otherwise stay. OE/WE are ignored in IDLE.
- ACTIVE, CS=1: return to IDLE the next cycle. Discard in-flight read beats. GPMC_DATA_OE=0 from the next edge. No MEM strobe is issued in that cycle.
- ACTIVE, CS=0, ADV=0: re-latch addr from AD_IN. This starts a new access. No strobe is issued in that cycle, even if WE or OE is low.
- ACTIVE write beat (CS=0, ADV=1, WE=0): registered outputs at next edge are MEM_ADDR=addr, MEM_WDATA=AD_IN, MEM_BE={~BE1,~BE0}, MEM_WE=1 for one cycle, and addr <= addr+1.
  - If WP=0: MEM_WE stays 0 and WP_VIOL=1 for one cycle. addr still increments.
  - If BE0=BE1=1: MEM_WE still pulses with MEM_BE=00.
- ACTIVE read beat (CS=0, ADV=1, OE=0, WE=1): next edge MEM_ADDR=addr, MEM_RE=1 for one cycle, and addr <= addr+1.
  - One edge later MEM_RDATA is registered into GPMC_DATA_OUT with GPMC_DATA_OE=1.
  - Read latency is 2 GPMC_CLK edges from the first sampled OE=0 to data on the bus. Back-to-back OE-low cycles stream one word per cycle.
- WE=0 and OE=0 together: treated as a write beat. No MEM_RE is issued.
- GPMC_DATA_OE: 1 only in a cycle following a valid read-pipeline stage. It drops to 0 the cycle after the pipeline empties. GPMC_DATA_OUT holds its last value when OE drops.
- Address increment wraps modulo 2^ADDR_WIDTH, so all-ones is followed by 0.
- MEM_WE and MEM_RE are never 1 in the same cycle.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles with CS=0/ADV=0 toggling -> all outputs 0, no MEM strobes; first cycle after release is in IDLE.
- Single write: ADV=0 with AD=0x0012, then WE=0 with AD=0xBEEF, BE0=BE1=0, WP=1 -> one MEM_WE pulse, MEM_ADDR=0x012, MEM_WDATA=0xBEEF, MEM_BE=11.
- Burst read with wrap (ADDR_WIDTH=10): ADV at 0x3FE, OE=0 for 3 cycles, SRAM model returning addr^0xA5A5 -> MEM_RE at 0x3FE, 0x3FF, 0x000 on consecutive cycles. GPMC_DATA_OUT shows 0xA65B, 0xA65A, 0xA5A5 starting 2 edges after the first OE=0. DATA_OE deasserts one cycle after the last word.
- Write protect and byte lanes: WP=0 with a write beat at 0x005 -> no MEM_WE, WP_VIOL single pulse, next beat targets 0x006. With WP=1, BE1=1 and BE0=0 -> MEM_BE=01.
- CS abort mid-read: CS goes high one cycle after the first OE=0 -> no GPMC_DATA_OE assertion, state IDLE. A new ADV cycle then works normally.
- WE and OE both low at addr 0x040 -> MEM_WE=1 and MEM_RE=0. ADV re-asserted mid-burst with 0x100 -> the next beat uses 0x100.
